// File: rtl/matrix_scan_controller_if.sv
// Bus between the scan controller, the digit-value logic, the shared converter and the matrix drivers.
// Carries the optional i_dim_level input when SCAN_DIMMING_EN is defined.
interface matrix_scan_controller_if #(
   parameter int DIGITS = 4
);
   logic                  i_enable;
   logic                  i_load;
   logic [7*DIGITS-1:0]   i_segments_in;
   logic [4:0]            i_bits_in;
   logic [6:0]            o_seg_sel;
   logic [2:0]            o_line_sel;
   logic [4:0]            o_row_en;
   logic [5*DIGITS-1:0]   o_col_data;
   logic                  o_frame_done;
`ifdef SCAN_DIMMING_EN
   logic [4:0]            i_dim_level;
`endif

   modport slave (
      input  i_enable, i_load, i_segments_in, i_bits_in,
`ifdef SCAN_DIMMING_EN
      input  i_dim_level,
`endif
      output o_seg_sel, o_line_sel, o_row_en, o_col_data, o_frame_done
   );

   modport master (
      output i_enable, i_load, i_segments_in, i_bits_in,
`ifdef SCAN_DIMMING_EN
      output i_dim_level,
`endif
      input  o_seg_sel, o_line_sel, o_row_en, o_col_data, o_frame_done
   );
endinterface

// File: rtl/matrix_scan_controller.sv
// Time-multiplexed 5-line LED matrix scanner sharing one segment-to-bitmap converter across DIGITS digits.
// Optional feature macro SCAN_DIMMING_EN adds 16-slot PWM dimming of row_en via i_dim_level.
module matrix_scan_controller #(
   parameter int DIGITS      = 4,
   parameter int HOLD_CYCLES = 1024
) (
   input logic                     clk,
   input logic                     rst,
   matrix_scan_controller_if.slave bus
);

   localparam int HW = $clog2(HOLD_CYCLES);
   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_GATHER = 2'd1;
   localparam logic [1:0] S_SHOW   = 2'd2;
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_PRE  = HW'(HOLD_CYCLES - 2);
   localparam logic [2:0]    DIG_LAST  = 3'(DIGITS - 1);

   logic [1:0]            r_state;
   logic [2:0]            r_line;
   logic [2:0]            r_dig;
   logic [HW-1:0]         r_hold;
   logic [7*DIGITS-1:0]   r_pend;
   logic [7*DIGITS-1:0]   r_disp;
   logic [5*DIGITS-1:0]   r_gather;
   logic [6:0]            r_seg_sel;
   logic [2:0]            r_line_sel;
   logic [4:0]            r_row_en;
   logic [5*DIGITS-1:0]   r_col_data;
   logic                  r_frame_done;

   logic [5*DIGITS-1:0]   w_gather_nxt;
   logic [6:0]            w_seg_nxt;
   logic [2:0]            w_line_nxt;
   logic [HW-1:0]         w_hold_inc;
   logic                  w_lit_first;
   logic                  w_lit_next;

   function automatic logic [4:0] line_onehot(input logic [2:0] line);
      return 5'(5'b00001 << line);
   endfunction

   assign w_hold_inc = r_hold + 1'b1;
   assign w_line_nxt = (r_line == 3'd4) ? 3'd0 : r_line + 3'd1;

`ifdef SCAN_DIMMING_EN
   // PWM slot is the low nibble of the hold count the row_en register is about to show.
   assign w_lit_first = (5'd0 < bus.i_dim_level);
   assign w_lit_next  = ({1'b0, w_hold_inc[3:0]} < bus.i_dim_level);
`else
   assign w_lit_first = 1'b1;
   assign w_lit_next  = 1'b1;
`endif

   always_comb begin
      w_gather_nxt = r_gather;
      for (int d = 0; d < DIGITS; d++) begin
         if (r_dig == 3'(d)) w_gather_nxt[5*d +: 5] = bus.i_bits_in;
      end
   end

   always_comb begin
      w_seg_nxt = r_disp[6:0];
      for (int d = 0; d < DIGITS; d++) begin
         if (r_dig + 3'd1 == 3'(d)) w_seg_nxt = r_disp[7*d +: 7];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_line       <= '0;
         r_dig        <= '0;
         r_hold       <= '0;
         r_pend       <= '0;
         r_disp       <= '0;
         r_gather     <= '0;
         r_seg_sel    <= '0;
         r_line_sel   <= '0;
         r_row_en     <= '0;
         r_col_data   <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         if (bus.i_load) r_pend <= bus.i_segments_in;
         if (!bus.i_enable) begin
            r_state    <= S_IDLE;
            r_line     <= '0;
            r_dig      <= '0;
            r_hold     <= '0;
            r_row_en   <= '0;
            r_col_data <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_state    <= S_GATHER;
                  r_line     <= '0;
                  r_dig      <= '0;
                  r_disp     <= r_pend;
                  r_seg_sel  <= r_pend[6:0];
                  r_line_sel <= '0;
               end
               S_GATHER: begin
                  r_gather <= w_gather_nxt;
                  if (r_dig == DIG_LAST) begin
                     r_state    <= S_SHOW;
                     r_dig      <= '0;
                     r_hold     <= '0;
                     r_col_data <= w_gather_nxt;
                     r_row_en   <= w_lit_first ? line_onehot(r_line) : 5'd0;
                  end else begin
                     r_dig     <= r_dig + 3'd1;
                     r_seg_sel <= w_seg_nxt;
                  end
               end
               S_SHOW: begin
                  if (r_hold == HOLD_LAST) begin
                     r_state    <= S_GATHER;
                     r_hold     <= '0;
                     r_row_en   <= '0;
                     r_line     <= w_line_nxt;
                     r_line_sel <= w_line_nxt;
                     // Frame boundary: latch the pending pattern so a frame never mixes two loads.
                     if (r_line == 3'd4) begin
                        r_disp    <= r_pend;
                        r_seg_sel <= r_pend[6:0];
                     end else begin
                        r_seg_sel <= r_disp[6:0];
                     end
                  end else begin
                     r_hold   <= w_hold_inc;
                     r_row_en <= w_lit_next ? line_onehot(r_line) : 5'd0;
                     if (r_line == 3'd4 && r_hold == HOLD_PRE) r_frame_done <= 1'b1;
                  end
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

   assign bus.o_seg_sel    = r_seg_sel;
   assign bus.o_line_sel   = r_line_sel;
   assign bus.o_row_en     = r_row_en;
   assign bus.o_col_data   = r_col_data;
   assign bus.o_frame_done = r_frame_done;

endmodule

// File: tb/tb_matrix_scan_controller.sv
// Bench for matrix_scan_controller: glyph-table converter, frame-timeline model and directed scenarios.
module tb_matrix_scan_controller;

   localparam int DIGITS = 2;
   localparam int HOLD   = 16;
   localparam int LP     = DIGITS + HOLD;
   localparam int FP     = 5 * LP;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   bit   started  = 1'b0;

   matrix_scan_controller_if #(.DIGITS(DIGITS)) bus ();

   matrix_scan_controller #(.DIGITS(DIGITS), .HOLD_CYCLES(HOLD)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [4:0] conv(input logic [6:0] seg, input logic [2:0] line);
      logic [4:0] r;
      case (seg)
         7'h06:   r = 5'b10000;
         7'h7F:   r = (line == 3'd1 || line == 3'd3) ? 5'b10001 : 5'b01110;
         default: r = seg[4:0] ^ {seg[6:5], line};
      endcase
      return r;
   endfunction

   function automatic logic [5*DIGITS-1:0] exp_cols(input logic [7*DIGITS-1:0] fr, input int line);
      logic [5*DIGITS-1:0] r;
      r = '0;
      for (int d = 0; d < DIGITS; d++) r[5*d +: 5] = conv(fr[7*d +: 7], 3'(line));
      return r;
   endfunction

   always_comb bus.i_bits_in = conv(bus.o_seg_sel, bus.o_line_sel);

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s: timed out (cycle %0d)", name, cyc);
   endtask

   // Model: position in the frame timeline since enable was first seen, plus frame snapshot.
   bit                  m_run;
   int                  m_t;
   logic [7*DIGITS-1:0] m_pend, m_frame;
   logic [4:0]          m_dim;

   always @(posedge clk) begin
      cyc     <= cyc + 1;
      started <= 1'b1;
`ifdef SCAN_DIMMING_EN
      m_dim <= bus.i_dim_level;
`else
      m_dim <= 5'd16;
`endif
      if (rst) begin
         m_run   <= 1'b0;
         m_t     <= 0;
         m_pend  <= '0;
         m_frame <= '0;
      end else begin
         if (bus.i_load) m_pend <= bus.i_segments_in;
         if (!bus.i_enable) begin
            m_run <= 1'b0;
            m_t   <= 0;
         end else if (!m_run) begin
            m_run   <= 1'b1;
            m_t     <= 0;
            m_frame <= m_pend;
         end else begin
            m_t <= m_t + 1;
            if ((m_t + 1) % FP == 0) m_frame <= m_pend;
         end
      end
   end

   always @(negedge clk) begin
      if (started) begin
         if (!m_run) begin
            chk("idle_row_en", 64'(bus.o_row_en), 64'd0);
            chk("idle_col_data", 64'(bus.o_col_data), 64'd0);
            chk("idle_frame_done", 64'(bus.o_frame_done), 64'd0);
         end else begin
            int phase, line, slot;
            logic [4:0] er;
            phase = m_t % LP;
            line  = (m_t / LP) % 5;
            slot  = (phase - DIGITS) % 16;
            er    = (phase >= DIGITS && slot < int'(m_dim)) ? 5'(5'b00001 << line) : 5'd0;
            chk("row_en", 64'(bus.o_row_en), 64'(er));
            chk("frame_done", 64'(bus.o_frame_done), 64'(line == 4 && phase == LP - 1));
            if (phase >= DIGITS) begin
               chk("col_data", 64'(bus.o_col_data), 64'(exp_cols(m_frame, line)));
            end else begin
               chk("seg_sel", 64'(bus.o_seg_sel), 64'(m_frame[7*phase +: 7]));
               chk("line_sel", 64'(bus.o_line_sel), 64'(line));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_row(input logic [4:0] v, input string name);
      int i;
      for (i = 0; i < 300; i++) begin
         tick();
         if (bus.o_row_en == v) break;
      end
      if (i >= 300) timeout(name);
   endtask

   task automatic wait_fd(output int at);
      int i;
      at = -1;
      for (i = 0; i < 300; i++) begin
         tick();
         if (bus.o_frame_done) begin
            at = cyc;
            break;
         end
      end
      if (i >= 300) timeout("wait_frame_done");
   endtask

   task automatic check_latency(input string name);
      int i;
      for (i = 1; i <= 50; i++) begin
         tick();
         if (bus.o_row_en != 5'd0) break;
      end
      chk(name, 64'(i), 64'(DIGITS + 1));
   endtask

   initial begin
      int c0, c1, cnt;
      rst              = 1'b1;
      bus.i_enable     = 1'b1;
      bus.i_load       = 1'b1;
      bus.i_segments_in = {7'h7F, 7'h06};
`ifdef SCAN_DIMMING_EN
      bus.i_dim_level  = 5'd16;
`endif
      repeat (3) tick();
      chk("rst_row_en", 64'(bus.o_row_en), 64'd0);
      chk("rst_col_data", 64'(bus.o_col_data), 64'd0);
      chk("rst_seg_sel", 64'(bus.o_seg_sel), 64'd0);
      chk("rst_line_sel", 64'(bus.o_line_sel), 64'd0);
      chk("rst_frame_done", 64'(bus.o_frame_done), 64'd0);

      rst          = 1'b0;
      bus.i_enable = 1'b0;
      bus.i_load   = 1'b0;
      tick();
      chk("post_rst_row_en", 64'(bus.o_row_en), 64'd0);

      bus.i_segments_in = {7'h06, 7'h7F};
      bus.i_load = 1'b1;
      tick();
      bus.i_load = 1'b0;
      bus.i_enable = 1'b1;
      check_latency("enable_latency");
      chk("line0_row_en", 64'(bus.o_row_en), 64'(5'b00001));
      chk("line0_cols", 64'(bus.o_col_data), 64'({5'b10000, 5'b01110}));
      repeat (LP) tick();
      chk("line1_row_en", 64'(bus.o_row_en), 64'(5'b00010));
      chk("line1_cols", 64'(bus.o_col_data), 64'({5'b10000, 5'b10001}));

      wait_fd(c0);
      wait_fd(c1);
      chk("frame_period", 64'(c1 - c0), 64'd90);
      cnt = 0;
      repeat (FP) begin
         tick();
         if (bus.o_frame_done) cnt++;
      end
      chk("frame_done_per_frame", 64'(cnt), 64'd1);

      // New pattern mid-frame stays hidden until the next frame.
      wait_row(5'b00100, "wait_line2");
      bus.i_segments_in = {7'h7F, 7'h7F};
      bus.i_load = 1'b1;
      tick();
      bus.i_load = 1'b0;
      wait_row(5'b10000, "wait_line4");
      chk("line4_old_cols", 64'(bus.o_col_data), 64'({5'b10000, 5'b01110}));
      wait_row(5'b00001, "wait_next_line0");
      chk("midload_cols", 64'(bus.o_col_data), 64'({5'b01110, 5'b01110}));

      // Load on the edge that starts a frame is deferred one frame.
      wait_fd(c0);
      bus.i_segments_in = {7'h06, 7'h06};
      bus.i_load = 1'b1;
      tick();
      bus.i_load = 1'b0;
      wait_row(5'b00001, "wait_boundary_line0");
      chk("boundary_deferred", 64'(bus.o_col_data), 64'({5'b01110, 5'b01110}));
      wait_fd(c0);
      wait_row(5'b00001, "wait_applied_line0");
      chk("boundary_applied", 64'(bus.o_col_data), 64'({5'b10000, 5'b10000}));

      wait_row(5'b01000, "wait_line3");
      bus.i_enable = 1'b0;
      tick();
      chk("drop_row_en", 64'(bus.o_row_en), 64'd0);
      chk("drop_col_data", 64'(bus.o_col_data), 64'd0);
      repeat (3) tick();
      bus.i_enable = 1'b1;
      check_latency("reenable_latency");
      chk("reenable_row_en", 64'(bus.o_row_en), 64'(5'b00001));
      chk("reenable_cols", 64'(bus.o_col_data), 64'({5'b10000, 5'b10000}));

`ifdef SCAN_DIMMING_EN
      bus.i_enable = 1'b0;
      bus.i_dim_level = 5'd4;
      tick();
      bus.i_enable = 1'b1;
      repeat (DIGITS + 1) tick();
      cnt = 0;
      repeat (HOLD) begin
         if (bus.o_row_en != 5'd0) cnt++;
         tick();
      end
      chk("dim4_lit_slots", 64'(cnt), 64'd4);
      bus.i_enable = 1'b0;
      bus.i_dim_level = 5'd0;
      tick();
      bus.i_enable = 1'b1;
      cnt = 0;
      repeat (FP) begin
         tick();
         if (bus.o_row_en != 5'd0) cnt++;
      end
      chk("dim0_dark", 64'(cnt), 64'd0);
      bus.i_dim_level = 5'd16;
`endif

      repeat (LP) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
